// File: rtl/ex_pipe_stage_if.sv
// Valid/ready stream bundle carrying a control vector and a data payload.
// A beat transfers on a rising clk edge where valid & ready are both 1; valid/ctrl/data must not depend on ready.
interface ex_pipe_stage_if #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 160
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (output valid, output ctrl, output data, input ready);
  modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/ex_pipe_stage.sv
// Execute-stage pipeline register: main entry M plus skid entry S so in_ready is registered.
// Bubbles always present a zero control vector; flush and reset discard every held entry.
module ex_pipe_stage #(
  parameter int CTRL_W     = 16,
  parameter int DATA_W     = 160,
  parameter bit CLEAR_DATA = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  ex_pipe_stage_if.slave      in_if,
  ex_pipe_stage_if.master     out_if,
  output logic [1:0]          occupancy,
  output logic [1:0]          dbg_state_o
);

  // State encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q;
  logic [CTRL_W-1:0] m_ctrl_q;
  logic [DATA_W-1:0] m_data_q;
  logic [CTRL_W-1:0] s_ctrl_q;
  logic [DATA_W-1:0] s_data_q;

  logic m_full;
  logic in_fire;
  logic out_fire;

  assign m_full      = (state_q != ST_EMPTY);
  assign in_if.ready = (state_q != ST_TWO) & ~reset;
  assign in_fire     = in_if.valid & in_if.ready;
  assign out_fire    = m_full & out_if.ready;

  assign out_if.valid = m_full;
  assign out_if.ctrl  = m_ctrl_q;
  assign out_if.data  = m_data_q;
  assign occupancy    = state_q;
  assign dbg_state_o  = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
    end else if (flush) begin
      state_q  <= ST_EMPTY;
      m_ctrl_q <= '0;
      if (CLEAR_DATA) m_data_q <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            m_ctrl_q <= in_if.ctrl;
            m_data_q <= in_if.data;
            state_q  <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (out_fire && in_fire) begin
            m_ctrl_q <= in_if.ctrl;
            m_data_q <= in_if.data;
          end else if (out_fire) begin
            m_ctrl_q <= '0;
            if (CLEAR_DATA) m_data_q <= '0;
            state_q  <= ST_EMPTY;
          end else if (in_fire) begin
            s_ctrl_q <= in_if.ctrl;
            s_data_q <= in_if.data;
            state_q  <= ST_TWO;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only the downstream side can move.
          if (out_fire) begin
            m_ctrl_q <= s_ctrl_q;
            m_data_q <= s_data_q;
            state_q  <= ST_ONE;
          end
        end
        default: begin
          state_q  <= ST_EMPTY;
          m_ctrl_q <= '0;
        end
      endcase
    end
  end

endmodule
